fifo_bist: RTL

Synthesizable, parametrised built-in self-test engine for the Pango width-converting FIFO IP (cdc_fifo family). It drives the FIFO write port with a deterministic pattern, reads the read port under independent throttling, and checks every read word against a model of the width conversion. It supports up- and down-conversion, sequential or concurrent traffic, and output-register latency, and reports saturating error and word counts. It sits beside the FIFO instance in both the on-board test image and simulation; wr/rd clocks are tied to the single `clk`.

---
 rtl/fifo_bist_pkg.sv | 32 +++
 rtl/fifo_bist_model.sv | 35 +++
 rtl/fifo_bist.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_bist_pkg.sv
// rtl/fifo_bist_pkg.sv - shared types, constants and parameter helpers for fifo_bist
package fifo_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Feedback taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CNT_W = 21;

  function automatic int conv_ratio(input int wr, input int rd);
    return (rd >= wr) ? rd / wr : wr / rd;
  endfunction

  function automatic int num_rd_words(input int wr, input int rd, input int n);
    return (n * wr) / rd;
  endfunction

  function automatic bit cfg_legal(input int wr, input int rd, input int n);
    if (wr <= 0 || rd <= 0 || n <= 0) return 1'b0;
    if (rd >= wr) return (rd % wr == 0) && (n % (rd / wr) == 0);
    return (wr % rd == 0);
  endfunction

endpackage

// File: rtl/fifo_bist_model.sv
// rtl/fifo_bist_model.sv - expected read word for a read index under little-endian width conversion
module fifo_bist_model
  import fifo_bist_pkg::*;
#(
  parameter int WR_DATA_WIDTH = 8,
  parameter int RD_DATA_WIDTH = 16
) (
  input  logic [CNT_W-1:0]         rd_idx,
  output logic [RD_DATA_WIDTH-1:0] exp_word,
  output logic [CNT_W-1:0]         word_idx
);

  localparam int K = conv_ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);

  // Pattern word i is the all-ones start value minus i, i.e. ~i modulo the write width
  if (RD_DATA_WIDTH >= WR_DATA_WIDTH) begin : g_up
    always_comb begin
      word_idx = rd_idx * CNT_W'(K);
      exp_word = '0;
      for (int i = 0; i < K; i++) begin
        exp_word[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = ~WR_DATA_WIDTH'(word_idx + CNT_W'(i));
      end
    end
  end else begin : g_dn
    logic [WR_DATA_WIDTH-1:0] pat;
    logic [CNT_W-1:0]         slice;
    always_comb begin
      word_idx = rd_idx / CNT_W'(K);
      slice    = rd_idx % CNT_W'(K);
      pat      = ~WR_DATA_WIDTH'(word_idx);
      exp_word = pat[slice*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  end

endmodule

// File: rtl/fifo_bist.sv
// rtl/fifo_bist.sv - self-test engine driving and checking a width-converting FIFO
module fifo_bist
  import fifo_bist_pkg::*;
#(
  parameter int          WR_DATA_WIDTH = 8,
  parameter int          RD_DATA_WIDTH = 16,
  parameter int          NUM_WR_WORDS  = 1024,
  parameter string       MODE          = "SEQ",
  parameter int          OUTPUT_REG    = 0,
  parameter int          WR_DUTY       = 16,
  parameter int          RD_DUTY       = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     tb_rst,
  input  logic                     start,
  output logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_en,
  input  logic                     wr_full,
  input  logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_en,
  input  logic                     rd_empty,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_cnt,
  output logic [CNT_W-1:0]         wr_cnt,
  output logic [CNT_W-1:0]         rd_cnt
);

  localparam int               NUM_RD     = num_rd_words(WR_DATA_WIDTH, RD_DATA_WIDTH, NUM_WR_WORDS);
  localparam logic [CNT_W-1:0] NUM_WR_C   = CNT_W'(NUM_WR_WORDS);
  localparam logic [CNT_W-1:0] NUM_RD_C   = CNT_W'(NUM_RD);
  localparam logic [1:0]       DRAIN_LAST = 2'(OUTPUT_REG + 1);
  localparam logic [4:0]       WR_DUTY_L  = 5'(WR_DUTY);
  localparam logic [4:0]       RD_DUTY_L  = 5'(RD_DUTY);
  localparam bit               CONC       = (MODE == "CONC");

  if (!cfg_legal(WR_DATA_WIDTH, RD_DATA_WIDTH, NUM_WR_WORDS) || WR_DUTY < 1 || WR_DUTY > 16 ||
      RD_DUTY < 1 || RD_DUTY > 16 || LFSR_SEED == 16'h0 || OUTPUT_REG < 0 || OUTPUT_REG > 1 ||
      (MODE != "SEQ" && MODE != "CONC")) begin : g_bad_cfg
    $error("fifo_bist: illegal parameter set");
  end

  state_t                   state_q, state_d;
  logic [15:0]              lfsr;
  logic [1:0]               drain_cnt;
  logic                     extra_seen;
  logic                     vld0;
  logic [RD_DATA_WIDTH-1:0] word0;
  logic                     cmp_vld;
  logic [RD_DATA_WIDTH-1:0] cmp_word;
  logic [RD_DATA_WIDTH-1:0] exp_word;
  logic [CNT_W-1:0]         unused_model_idx;
  logic                     start_ok, wr_req, rd_req, mismatch, extra, err_inc;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wr_req   = {1'b0, lfsr[3:0]} < WR_DUTY_L;
  assign rd_req   = {1'b0, lfsr[7:4]} < RD_DUTY_L;
  assign busy     = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (err_cnt == 8'h00);

  fifo_bist_model #(
    .WR_DATA_WIDTH(WR_DATA_WIDTH),
    .RD_DATA_WIDTH(RD_DATA_WIDTH)
  ) u_model (
    .rd_idx  (rd_cnt),
    .exp_word(exp_word),
    .word_idx(unused_model_idx)
  );

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = CONC ? ST_STREAM : ST_WRITE;
      ST_WRITE: begin
        wr_en = wr_req && !wr_full && (wr_cnt < NUM_WR_C);
        if (wr_cnt == NUM_WR_C) state_d = ST_READ;
      end
      ST_READ, ST_STREAM: begin
        if (state_q == ST_STREAM) wr_en = wr_req && !wr_full && (wr_cnt < NUM_WR_C);
        rd_en = rd_req && !rd_empty && (rd_cnt < NUM_RD_C);
        if (rd_cnt == NUM_RD_C) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)        lfsr <= LFSR_SEED;
    else if (start_ok) lfsr <= LFSR_SEED;
    else               lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // The delay line tap matches the FIFO read latency so the expected word lines up with rd_data
  if (OUTPUT_REG != 0) begin : g_oreg
    logic                     vld1;
    logic [RD_DATA_WIDTH-1:0] word1;
    always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
        vld1  <= 1'b0;
        word1 <= '0;
      end else begin
        vld1  <= vld0 && !start_ok;
        word1 <= word0;
      end
    end
    assign cmp_vld  = vld1;
    assign cmp_word = word1;
  end else begin : g_noreg
    assign cmp_vld  = vld0;
    assign cmp_word = word0;
  end

  assign mismatch = cmp_vld && (rd_data != cmp_word);
  assign extra    = (state_q == ST_DONE) && !rd_empty && !extra_seen;
  assign err_inc  = mismatch || extra;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_data    <= '1;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      err_cnt    <= '0;
      extra_seen <= 1'b0;
      vld0       <= 1'b0;
      word0      <= '0;
      drain_cnt  <= '0;
    end else if (start_ok) begin
      wr_data    <= '1;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      err_cnt    <= '0;
      extra_seen <= 1'b0;
      vld0       <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      if (wr_en) begin
        wr_data <= wr_data - 1'b1;
        wr_cnt  <= wr_cnt + 1'b1;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        word0  <= exp_word;
      end
      vld0 <= rd_en;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (extra) extra_seen <= 1'b1;
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 1'b1 : 2'd0;
    end
  end

endmodule
